// File: rtl/goto_repetition_detector_if.sv
// goto_repetition_detector_if: a/b event inputs and match/status outputs of the goto-repetition monitor
interface goto_repetition_detector_if #(
  parameter int N_HITS = 2,
  parameter int STAT_W = 16
);
  logic a;
  logic b;
  logic busy;
  logic [$clog2(N_HITS+1)-1:0] hits;
  logic match;
  logic [STAT_W-1:0] match_count;
  logic timeout;
  modport master(output a, b, input busy, hits, match, match_count, timeout);
  modport slave(input a, b, output busy, hits, match, match_count, timeout);
endinterface

// File: rtl/goto_repetition_detector.sv
// goto_repetition_detector: detects "a ##1 b [->N_HITS]" with a registered match pulse; optional gap timeout via GOTO_TIMEOUT_EN
module goto_repetition_detector #(
  parameter int N_HITS = 2,
  parameter int MAX_GAP = 8,
  parameter int STAT_W = 16
) (
  input logic clk,
  input logic rst,
  goto_repetition_detector_if.slave bus
);
  localparam int HW = $clog2(N_HITS+1);
  localparam logic [HW-1:0] LAST = HW'(N_HITS-1);
  if (N_HITS < 1) begin : g_bad_hits
    $error("N_HITS must be >= 1");
  end
  if (MAX_GAP < 1) begin : g_bad_gap
    $error("MAX_GAP must be >= 1");
  end
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state, state_n;
  logic [HW-1:0] hits, hits_n;
  logic match, match_n;
  logic [STAT_W-1:0] match_count;
`ifdef GOTO_TIMEOUT_EN
  localparam int GW = $clog2(MAX_GAP+1);
  localparam logic [GW-1:0] GAP_LAST = GW'(MAX_GAP-1);
  logic [GW-1:0] gap, gap_n;
  logic timeout, timeout_n;
`endif
  always_comb begin
    state_n = state;
    hits_n = hits;
    match_n = 1'b0;
`ifdef GOTO_TIMEOUT_EN
    gap_n = gap;
    timeout_n = 1'b0;
`endif
    if (state == IDLE) begin
      if (bus.a) begin
        state_n = ARMED;
        hits_n = '0;
`ifdef GOTO_TIMEOUT_EN
        gap_n = '0;
`endif
      end
    end else if (bus.b) begin
`ifdef GOTO_TIMEOUT_EN
      gap_n = '0;
`endif
      if (hits == LAST) begin
        state_n = IDLE;
        hits_n = '0;
        match_n = 1'b1;
      end else begin
        hits_n = hits + 1'b1;
      end
    end
`ifdef GOTO_TIMEOUT_EN
    else if (gap == GAP_LAST) begin
      state_n = IDLE;
      hits_n = '0;
      timeout_n = 1'b1;
    end else begin
      gap_n = gap + 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hits <= '0;
      match <= 1'b0;
      match_count <= '0;
    end else begin
      state <= state_n;
      hits <= hits_n;
      match <= match_n;
      if (match_n && !(&match_count)) match_count <= match_count + 1'b1;
    end
  end
`ifdef GOTO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gap <= '0;
      timeout <= 1'b0;
    end else begin
      gap <= gap_n;
      timeout <= timeout_n;
    end
  end
  assign bus.timeout = timeout;
`else
  assign bus.timeout = 1'b0;
`endif
  assign bus.busy = (state == ARMED);
  assign bus.hits = hits;
  assign bus.match = match;
  assign bus.match_count = match_count;
endmodule

// File: tb/tb_goto_repetition_detector.sv
// tb_goto_repetition_detector: table-driven and directed checks of the goto-repetition monitor
module tb_goto_repetition_detector;
  localparam int N_HITS = 2;
  localparam int MAX_GAP = 8;
  localparam int STAT_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  goto_repetition_detector_if #(.N_HITS(N_HITS), .STAT_W(STAT_W)) bus ();
  goto_repetition_detector #(.N_HITS(N_HITS), .MAX_GAP(MAX_GAP), .STAT_W(STAT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic rst;
    logic a;
    logic b;
    logic busy;
    logic [1:0] hits;
    logic match;
    logic [1:0] cnt;
    logic timeout;
  } vec_t;
  vec_t vecs [64];
  int n_vec = 0;
  task automatic add(input logic r, input logic a, input logic b, input logic busy,
                     input logic [1:0] hits, input logic match, input logic [1:0] cnt);
    vecs[n_vec] = '{r, a, b, busy, hits, match, cnt, 1'b0};
    n_vec++;
  endtask
  task automatic step(input logic r, input logic a, input logic b);
    rst = r;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  initial begin
    bus.a = 1'b0;
    bus.b = 1'b0;
    // Each row: inputs applied before an edge, outputs expected right after it.
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < n_vec; i++) begin
      step(vecs[i].rst, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d busy", i), int'(bus.busy), int'(vecs[i].busy));
      chk($sformatf("v%0d hits", i), int'(bus.hits), int'(vecs[i].hits));
      chk($sformatf("v%0d match", i), int'(bus.match), int'(vecs[i].match));
      chk($sformatf("v%0d match_count", i), int'(bus.match_count), int'(vecs[i].cnt));
      chk($sformatf("v%0d timeout", i), int'(bus.timeout), int'(vecs[i].timeout));
    end
    // Saturation, with a coincident a on every final b that must not re-arm.
    step(1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 0);
      chk($sformatf("sat%0d armed", k), int'(bus.busy), 1);
      step(0, 0, 1);
      chk($sformatf("sat%0d hits", k), int'(bus.hits), 1);
      step(0, 1, 1);
      chk($sformatf("sat%0d match", k), int'(bus.match), 1);
      chk($sformatf("sat%0d match_count", k), int'(bus.match_count), k < 3 ? k : 3);
      chk($sformatf("sat%0d no rearm", k), int'(bus.busy), 0);
      step(0, 0, 0);
      chk($sformatf("sat%0d pulse", k), int'(bus.match), 0);
    end
    // Gap expiry: b at c3, silence afterwards.
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 1'b0, i == 3);
`ifdef GOTO_TIMEOUT_EN
      chk($sformatf("gap c%0d timeout", i + 1), int'(bus.timeout), int'(i == 11));
      chk($sformatf("gap c%0d busy", i + 1), int'(bus.busy), int'(i < 11));
`else
      chk($sformatf("gap c%0d timeout", i + 1), int'(bus.timeout), 0);
      chk($sformatf("gap c%0d busy", i + 1), int'(bus.busy), 1);
`endif
      chk($sformatf("gap c%0d match", i + 1), int'(bus.match), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
